// File: rtl/defuse_pkg.sv
// Shared types and constants for the defuse sequencer and its countdown.
package defuse_pkg;

    // FSM state encoding, also driven out on state_o
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_DEFUSED  = 2'd2,
        ST_EXPLODED = 2'd3
    } state_e;

    localparam int NUM_WIRES = 8;
    localparam int IDX_W     = 3;
    localparam int SEQ_W     = NUM_WIRES * IDX_W;

    // Wire index expected at cut step k; step k lives in bits [3k+2:3k] of the order word
    function automatic logic [IDX_W-1:0] seq_at(input logic [SEQ_W-1:0] seq,
                                                 input logic [IDX_W-1:0] k);
        return seq[int'(k) * IDX_W +: IDX_W];
    endfunction

endpackage

// File: rtl/defuse_countdown.sv
// Loadable down-counter for the bomb timer.
// expire is combinational so the sequencer can leave ARMED on the same edge
// that the counter reaches zero.
module defuse_countdown #(
    parameter int            TW       = 7,
    parameter logic [TW-1:0] LOAD_VAL = TW'(60)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_tick,
    input  logic          i_hold,
    output logic [TW-1:0] o_time_left,
    output logic          o_expire
);

    logic [TW-1:0] r_time;
    logic          w_dec;

    // A tick only counts while the timer is running and still has time left
    assign w_dec       = i_tick && !i_hold && (r_time != '0);
    assign o_expire    = w_dec && (r_time == TW'(1));
    assign o_time_left = r_time;

    // Load on round start, otherwise count down one tick at a time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_time <= '0;
        end else if (i_load) begin
            r_time <= LOAD_VAL;
        end else if (w_dec) begin
            r_time <= r_time - TW'(1);
        end
    end

endmodule

// File: rtl/defuse_sequencer.sv
// Tracks wire cuts against the secret order and runs the round countdown.
// Produces the cut-wire vector consumed by the all-ones defuse checker.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | waiting for arm; tick and cuts ignored
//  ARMED     | round running; timer counts ticks, cuts checked against SEQ
//  DEFUSED   | all wires cut in order; outputs frozen until reset
//  EXPLODED  | wrong cut or timeout; outputs frozen until reset
module defuse_sequencer
    import defuse_pkg::*;
#(
    parameter logic [SEQ_W-1:0] SEQ       = 24'o52607413,
    parameter int               TIME_INIT = 60,
    parameter int               TW        = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 tick,
    input  logic                 cut_valid,
    input  logic [IDX_W-1:0]     cut_idx,
    output logic [NUM_WIRES-1:0] defuse_vec,
    output logic [1:0]           state_o,
    output logic                 defused,
    output logic                 exploded,
    output logic [TW-1:0]        time_left
);

    state_e               r_state;
    logic [IDX_W-1:0]     r_step;
    logic [NUM_WIRES-1:0] r_vec;
    logic                 r_defused;
    logic                 r_exploded;

    logic                 w_load;
    logic                 w_hold;
    logic                 w_expire;
    logic [IDX_W-1:0]     w_expected;
    logic                 w_cut_new;
    logic                 w_cut_ok;
    logic                 w_cut_bad;
    logic                 w_last;
    logic [NUM_WIRES-1:0] w_cut_bit;

    assign w_load     = (r_state == ST_IDLE) && arm;
    assign w_hold     = (r_state != ST_ARMED);
    assign w_expected = seq_at(SEQ, r_step);

    // A cut on an already-cut wire is a no-op, never a mistake
    assign w_cut_new  = cut_valid && !r_vec[cut_idx];
    assign w_cut_ok   = w_cut_new && (cut_idx == w_expected);
    assign w_cut_bad  = w_cut_new && (cut_idx != w_expected);
    assign w_last     = (r_step == IDX_W'(NUM_WIRES - 1));
    assign w_cut_bit  = NUM_WIRES'(1) << cut_idx;

    defuse_countdown #(
        .TW       (TW),
        .LOAD_VAL (TW'(TIME_INIT))
    ) u_countdown (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_tick      (tick),
        .i_hold      (w_hold),
        .o_time_left (time_left),
        .o_expire    (w_expire)
    );

    // Round FSM with step counter, cut vector and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_vec      <= '0;
            r_defused  <= 1'b0;
            r_exploded <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state <= ST_ARMED;
                        r_step  <= '0;
                        r_vec   <= '0;
                    end
                end
                ST_ARMED: begin
                    if (w_cut_ok) begin
                        r_vec <= r_vec | w_cut_bit;
                        if (w_last) begin
                            // Final correct cut beats a simultaneous timeout
                            r_state   <= ST_DEFUSED;
                            r_defused <= 1'b1;
                        end else begin
                            r_step <= r_step + IDX_W'(1);
                            if (w_expire) begin
                                r_state    <= ST_EXPLODED;
                                r_exploded <= 1'b1;
                            end
                        end
                    end else if (w_cut_bad || w_expire) begin
                        r_state    <= ST_EXPLODED;
                        r_exploded <= 1'b1;
                    end
                end
                default: begin
                    // Terminal states hold everything until reset
                end
            endcase
        end
    end

    assign defuse_vec = r_vec;
    assign state_o    = r_state;
    assign defused    = r_defused;
    assign exploded   = r_exploded;

endmodule
